wb_mem_arbiter: RTL and testbench

- Two-master, one-slave Wishbone B3 arbiter that shares the main-RAM port between the eco32f instruction bus (master 0) and data bus (master 1).
- Sits between the CPU bus masters and the ram_wb_b3 slave port, ahead of address masking.
- Round-robin grant, held for a whole Wishbone cycle including incrementing bursts.
- Optional bus watchdog turns a hung access into an error.

---
 rtl/wb_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone B3 arbiter for the shared RAM port.
// Optional bus watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   g0, g1;
  logic   stb_raw;
  logic   timeout;

  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

  // Next owner: fair tie-break in IDLE, hold while cyc, hand over on release
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          state_d = last_gnt_q ? GNT0 : GNT1;
        else if (m0_cyc_i)
          state_d = GNT0;
        else if (m1_cyc_i)
          state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i)
          state_d = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i)
          state_d = m0_cyc_i ? GNT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0)
      last_gnt_d = 1'b0;
    else if (state_d == GNT1)
      last_gnt_d = 1'b1;
  end

  // Owner state and round-robin history
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign grant_o = {g1, g0};

  // Slave side follows the owner; idle parks on master 0 values
  assign s_adr_o = g1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = g1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = g1 ? m1_sel_i : m0_sel_i;
  assign s_we_o  = g1 ? m1_we_i  : m0_we_i;
  assign s_cti_o = g1 ? m1_cti_i : m0_cti_i;
  assign s_bte_o = g1 ? m1_bte_i : m0_bte_i;
  assign s_cyc_o = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
  assign stb_raw = (g0 & m0_stb_i) | (g1 & m1_stb_i);
  assign s_stb_o = stb_raw & ~timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wdog_q, wdog_d;
  logic        stall;

  assign stall   = s_cyc_o & stb_raw & ~(s_ack_i | s_err_i | s_rty_i);
  assign timeout = stall & (wdog_q == WD_LAST);

  // Count unterminated strobe cycles of the current owner
  always_comb begin
    wdog_d = wdog_q + 16'd1;
    if ((state_d != state_q) || !stall || timeout)
      wdog_d = '0;
  end

  // Stall counter register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)
      wdog_q <= '0;
    else
      wdog_q <= wdog_d;
  end
`else
  // No watchdog: a legal TIMEOUT is never zero, so this is constant false
  assign timeout = (TIMEOUT == 0);
`endif

  // Read data is broadcast; terminations reach only an active owner
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = g0 & m0_cyc_i & s_ack_i;
  assign m0_err_o = g0 & m0_cyc_i & (s_err_i | timeout);
  assign m0_rty_o = g0 & m0_cyc_i & s_rty_i;
  assign m1_ack_o = g1 & m1_cyc_i & s_ack_i;
  assign m1_err_o = g1 & m1_cyc_i & (s_err_i | timeout);
  assign m1_rty_o = g1 & m1_cyc_i & s_rty_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter.
// Watchdog checks follow WB_ARB_TIMEOUT_EN.
module tb_wb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic [31:0] m0_rd, m1_rd;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [31:0] s_adr, s_wd, s_rd;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic        s_ack, s_err, s_rty;
  logic [1:0]  grant;

  int pass_cnt = 0;
  int total    = 0;

  wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_cti_i(m0_cti), .m0_bte_i(m0_bte), .m0_dat_o(m0_rd),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_cti_i(m1_cti), .m1_bte_i(m1_bte), .m1_dat_o(m1_rd),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_adr_o(s_adr), .s_dat_o(s_wd), .s_sel_o(s_sel),
    .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_cti_o(s_cti), .s_bte_o(s_bte), .s_dat_i(s_rd),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [2:0] cti0;
    logic [2:0] cti1;
    logic [2:0] rsp;
    logic [1:0] gnt;
    logic [1:0] cs;
    logic [2:0] scti;
    logic [2:0] r0;
    logic [2:0] r1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic [3:0] req, logic [2:0] c0, logic [2:0] c1,
    logic [2:0] rsp, logic [1:0] gnt, logic [1:0] cs,
    logic [2:0] scti, logic [2:0] r0, logic [2:0] r1);
    vec_t v;
    v.req = req; v.cti0 = c0; v.cti1 = c1; v.rsp = rsp;
    v.gnt = gnt; v.cs = cs; v.scti = scti;
    v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = v.req;
    m0_cti = v.cti0;
    m1_cti = v.cti1;
    {s_ack, s_err, s_rty} = v.rsp;
  endtask

  function automatic logic [12:0] ctl_now();
    return {grant, s_cyc, s_stb, s_cti,
            m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty};
  endfunction

  initial begin
    logic [12:0]  ectl;
    logic [100:0] ebus, abus;
    int           errs;
    vec_t         z;

    rst_n  = 1'b0;
    m0_adr = 32'h0000_0100; m1_adr = 32'h0000_0200;
    m0_dat = 32'h1111_1111; m1_dat = 32'h2222_2222;
    m0_sel = 4'hF; m1_sel = 4'h3;
    m0_we  = 1'b0; m1_we  = 1'b1;
    m0_bte = 2'b00; m1_bte = 2'b01;
    s_rd   = 32'hDEAD_BEEF;
    z = mk(4'b0000, 3'd0, 3'd0, 3'b000, 2'b00, 2'b00, 3'd0, 3'b000, 3'b000);
    drive(z);

    // tie after reset, release hand-over, second tie
    tbl.push_back(mk(4'b0000, 0, 0, 3'b000, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1111, 0, 0, 3'b000, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1111, 0, 0, 3'b100, 2'b01, 2'b11, 0, 3'b100, 3'b000));
    tbl.push_back(mk(4'b0011, 0, 0, 3'b000, 2'b01, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b0011, 0, 0, 3'b100, 2'b10, 2'b11, 0, 3'b000, 3'b100));
    tbl.push_back(mk(4'b0000, 0, 0, 3'b000, 2'b10, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1111, 0, 0, 3'b000, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1111, 0, 0, 3'b100, 2'b01, 2'b11, 0, 3'b100, 3'b000));
    tbl.push_back(mk(4'b0011, 0, 0, 3'b000, 2'b01, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b0011, 0, 0, 3'b100, 2'b10, 2'b11, 0, 3'b000, 3'b100));
    tbl.push_back(mk(4'b0000, 0, 0, 3'b000, 2'b10, 2'b00, 0, 3'b000, 3'b000));
    // single m0 read, ack after two wait cycles
    tbl.push_back(mk(4'b0000, 0, 0, 3'b000, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1100, 0, 0, 3'b000, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1100, 0, 0, 3'b000, 2'b01, 2'b11, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1100, 0, 0, 3'b000, 2'b01, 2'b11, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1100, 0, 0, 3'b100, 2'b01, 2'b11, 0, 3'b100, 3'b000));
    tbl.push_back(mk(4'b0000, 0, 0, 3'b000, 2'b01, 2'b00, 0, 3'b000, 3'b000));
    // m1 burst holds grant while m0 waits; ack in release cycle dropped
    tbl.push_back(mk(4'b0011, 0, 3'b010, 3'b000, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1111, 0, 3'b010, 3'b100, 2'b10, 2'b11, 3'b010, 3'b000, 3'b100));
    tbl.push_back(mk(4'b1111, 0, 3'b010, 3'b100, 2'b10, 2'b11, 3'b010, 3'b000, 3'b100));
    tbl.push_back(mk(4'b1110, 0, 3'b010, 3'b000, 2'b10, 2'b10, 3'b010, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1111, 0, 3'b010, 3'b100, 2'b10, 2'b11, 3'b010, 3'b000, 3'b100));
    tbl.push_back(mk(4'b1111, 0, 3'b111, 3'b100, 2'b10, 2'b11, 3'b111, 3'b000, 3'b100));
    tbl.push_back(mk(4'b1100, 0, 3'b000, 3'b100, 2'b10, 2'b00, 3'b000, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1100, 0, 0, 3'b100, 2'b01, 2'b11, 0, 3'b100, 3'b000));
    tbl.push_back(mk(4'b0000, 0, 0, 3'b000, 2'b01, 2'b00, 0, 3'b000, 3'b000));
    // err then rty to m0; idle ignores stray ack
    tbl.push_back(mk(4'b1100, 0, 0, 3'b000, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b1100, 0, 0, 3'b010, 2'b01, 2'b11, 0, 3'b010, 3'b000));
    tbl.push_back(mk(4'b1100, 0, 0, 3'b001, 2'b01, 2'b11, 0, 3'b001, 3'b000));
    tbl.push_back(mk(4'b0000, 0, 0, 3'b000, 2'b01, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b0000, 0, 0, 3'b100, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    // m0 drops while m1 raises in the same cycle
    tbl.push_back(mk(4'b1100, 0, 0, 3'b000, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b0011, 0, 0, 3'b000, 2'b01, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b0011, 0, 0, 3'b000, 2'b10, 2'b11, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b0000, 0, 0, 3'b000, 2'b10, 2'b00, 0, 3'b000, 3'b000));
    tbl.push_back(mk(4'b0000, 0, 0, 3'b000, 2'b00, 2'b00, 0, 3'b000, 3'b000));

    // reset state
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("reset_state", 160'(ctl_now()), 160'(13'd0));
    s_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      s_rd = 32'hDEAD_0000 + 32'(i);
      #1;
      ectl = {tbl[i].gnt, tbl[i].cs, tbl[i].scti,
              tbl[i].r0, tbl[i].r1};
      if (tbl[i].gnt == 2'b10)
        ebus = {32'h200, 32'h2222_2222, 1'b1, 4'h3,
                32'hDEAD_0000 + 32'(i)};
      else
        ebus = {32'h100, 32'h1111_1111, 1'b0, 4'hF,
                32'hDEAD_0000 + 32'(i)};
      abus = {s_adr, s_wd, s_we, s_sel, m0_rd};
      chk($sformatf("vec%0d", i),
          {m1_rd, 13'(ctl_now()), 14'd0, abus},
          {32'hDEAD_0000 + 32'(i), ectl, 14'd0, ebus});
    end

    // async reset in the middle of a stalled m1 write
    @(negedge clk);
    drive(z);
    {m1_cyc, m1_stb} = 2'b11;
    @(negedge clk);
    #1;
    chk("m1_write_grant", 160'({grant, s_cyc, s_stb}), 160'(4'b1011));
    @(posedge clk);
    #2;
    s_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 160'({grant, s_cyc, s_stb, m1_ack}),
        160'(5'b00000));
    @(negedge clk);
    s_ack = 1'b0;
    rst_n = 1'b1;
    {m0_cyc, m0_stb} = 2'b11;
    @(negedge clk);
    #1;
    chk("tie_after_async", 160'({grant, s_cyc}), 160'(3'b011));
    @(negedge clk);
    drive(z);
    @(negedge clk);

    // hung slave
    {m0_cyc, m0_stb} = 2'b11;
    @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk($sformatf("wdog_k%0d", k),
          160'({m0_err, s_stb, m1_err}),
          160'({k == 8, k != 8, 1'b0}));
      @(negedge clk);
    end
`else
    errs = 0;
    for (int k = 0; k < 1000; k++) begin
      #1;
      if (m0_err || !s_stb) errs++;
      @(negedge clk);
    end
    chk("no_wdog_1000", 160'(errs), 160'(0));
`endif
    drive(z);
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
